// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory, decode and redirect signals of the fetch unit.
interface fetch_unit_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] instruction;
    logic [31:0] pc_o;
    logic        branch_inst_wire;
    logic        jump_inst_wire;
    logic [31:0] alu_result_1;

    modport master (
        output o_imem_req, o_imem_addr, o_valid, instruction, pc_o,
        input  i_imem_rvalid, i_imem_rdata, i_ready,
               branch_inst_wire, jump_inst_wire, alu_result_1
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_valid, instruction, pc_o,
        output i_imem_rvalid, i_imem_rdata, i_ready,
               branch_inst_wire, jump_inst_wire, alu_result_1
    );
endinterface

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetch entries; flush empties it and wins over push/pop.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush && !rst;
    // a push into a full buffer is only legal when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop) && !flush && !rst;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: request FSM, fetch PC register and redirect handling in front of fetch_buf.
//   state   | meaning
//   IDLE    | no request outstanding; may issue one
//   WAIT    | one live request outstanding; response is pushed
//   DISCARD | outstanding response belongs to a flushed path; drop it
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    fetch_unit_if.master bus
);
    localparam logic [1:0] IDLE    = FETCH_IDLE;
    localparam logic [1:0] WAIT    = FETCH_WAIT;
    localparam logic [1:0] DISCARD = FETCH_DISCARD;

    logic [1:0]   state;
    logic [31:0]  fetch_pc;
    logic [31:0]  target;
    logic         redirect;
    logic         issue;
    logic         push;
    logic         pop;
    logic         buf_full;
    logic         buf_empty;
    fetch_entry_t head;
    fetch_entry_t push_data;

    assign redirect = bus.branch_inst_wire | bus.jump_inst_wire;
    assign target   = bus.alu_result_1 & ~32'd3;

    // In IDLE nothing is in flight, so "occupancy + in-flight < depth" reduces to !full.
    assign issue = !i_rst && (state == IDLE) && i_en && !redirect && !buf_full;
    assign push  = (state == WAIT) && bus.i_imem_rvalid && !redirect;
    assign pop   = bus.i_ready && !buf_empty && !redirect;

    assign push_data.pc    = fetch_pc;
    assign push_data.instr = bus.i_imem_rdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect)   fetch_pc <= target;
                    else if (issue) state    <= WAIT;
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc <= target;
                        // a response arriving with the redirect is simply dropped here
                        state    <= bus.i_imem_rvalid ? IDLE : DISCARD;
                    end else if (bus.i_imem_rvalid) begin
                        fetch_pc <= fetch_pc + INSTR_BYTES;
                        state    <= IDLE;
                    end
                end
                DISCARD: begin
                    if (redirect)          fetch_pc <= target;
                    if (bus.i_imem_rvalid) state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data (push_data),
        .head      (head),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign bus.o_imem_req  = issue;
    assign bus.o_imem_addr = fetch_pc;
    assign bus.o_valid     = !buf_empty;
    assign bus.instruction = buf_empty ? 32'd0 : head.instr;
    assign bus.pc_o        = buf_empty ? 32'd0 : head.pc;
endmodule
